// File: rtl/prescaled_counter_pkg.sv
// prescaled_counter_pkg: mode encodings and width helper shared by the counter files
package prescaled_counter_pkg;
  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/prescaled_counter_if.sv
// prescaled_counter_if: control (EN, MODE, LOAD, LOAD_VAL) and status (COUNT, TICK, TC, DIR) bundle
interface prescaled_counter_if #(parameter int WIDTH = 8);
  logic             EN;
  logic [1:0]       MODE;
  logic             LOAD;
  logic [WIDTH-1:0] LOAD_VAL;
  logic [WIDTH-1:0] COUNT;
  logic             TICK;
  logic             TC;
  logic             DIR;
  modport master (output EN, MODE, LOAD, LOAD_VAL, input COUNT, TICK, TC, DIR);
  modport slave (input EN, MODE, LOAD, LOAD_VAL, output COUNT, TICK, TC, DIR);
endinterface

// File: rtl/prescaled_counter_prescaler.sv
// tick_prescaler: divides MCLK by CLK_HZ/TICK_HZ; in MCLK, RESET, EN, CLR; out TICK_EN (step strobe)
module tick_prescaler
  import prescaled_counter_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic MCLK,
  input  logic RESET,
  input  logic EN,
  input  logic CLR,
  output logic TICK_EN
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW = clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  if (DIV < 1) begin : g_bad_div
    $error("tick_prescaler: CLK_HZ/TICK_HZ must be at least 1");
  end
  logic [PW-1:0] r_cnt;
  assign TICK_EN = EN && (r_cnt == LAST);
  always_ff @(posedge MCLK)
    if (RESET || CLR) r_cnt <= '0;
    else if (EN) r_cnt <= TICK_EN ? '0 : r_cnt + PW'(1);
endmodule

// File: rtl/prescaled_counter.sv
// prescaled_counter: prescaled WIDTH-bit up/down/bounce/hold counter; in MCLK, RESET, bus.EN/MODE/LOAD/LOAD_VAL; out bus.COUNT/TICK/TC/DIR
module prescaled_counter
  import prescaled_counter_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int WIDTH   = 8
) (
  input  logic MCLK,
  input  logic RESET,
  prescaled_counter_if.slave bus
);
  localparam logic [WIDTH-1:0] MAX = '1;
  logic             w_step;
  logic             w_up;
  logic             w_at_end;
  logic             w_bounce;
  logic             w_tc;
  logic             w_nbdir;
  logic             w_dir;
  logic [WIDTH-1:0] w_count;
  mode_t            w_mode;
  logic [WIDTH-1:0] r_count;
  logic             r_tick;
  logic             r_tc;
  logic             r_bdir;
  logic             r_dir;
  tick_prescaler #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_prescaler (
    .MCLK   (MCLK),
    .RESET  (RESET),
    .EN     (bus.EN),
    .CLR    (bus.LOAD),
    .TICK_EN(w_step)
  );
  always_comb begin
    w_mode   = mode_t'(bus.MODE);
    w_up     = (w_mode == MODE_UP) || (w_mode == MODE_BOUNCE && r_bdir);
    w_at_end = w_up ? (r_count == MAX) : (r_count == '0);
    w_bounce = (w_mode == MODE_BOUNCE) && w_at_end;
    w_tc     = (w_mode != MODE_HOLD) && w_at_end;
    w_count  = (w_mode == MODE_HOLD) ? r_count :
               w_bounce ? (w_up ? MAX - WIDTH'(1) : WIDTH'(1)) :
               w_up ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
    w_nbdir  = (w_step && !bus.LOAD && w_bounce) ? ~r_bdir : r_bdir;
    w_dir    = (w_mode == MODE_UP) ? 1'b1 : (w_mode == MODE_DOWN) ? 1'b0 : w_nbdir;
  end
  always_ff @(posedge MCLK)
    if (RESET) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_tc    <= 1'b0;
      r_bdir  <= 1'b1;
      r_dir   <= 1'b0;
    end else begin
      r_bdir  <= w_nbdir;
      r_dir   <= w_dir;
      r_count <= bus.LOAD ? bus.LOAD_VAL : w_step ? w_count : r_count;
      r_tick  <= !bus.LOAD && w_step;
      r_tc    <= !bus.LOAD && w_step && w_tc;
    end
  assign bus.COUNT = r_count;
  assign bus.TICK  = r_tick;
  assign bus.TC    = r_tc;
  assign bus.DIR   = r_dir;
endmodule

// File: tb/tb_prescaled_counter.sv
// tb_prescaled_counter: directed checks of prescaled_counter at DIV=4 and DIV=1
module tb_prescaled_counter;
  logic clk = 1'b0;
  logic rst4, rst1;
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  prescaled_counter_if #(.WIDTH(4)) b4 ();
  prescaled_counter_if #(.WIDTH(4)) b1 ();
  prescaled_counter #(.CLK_HZ(4), .TICK_HZ(1), .WIDTH(4)) dut4 (.MCLK(clk), .RESET(rst4), .bus(b4));
  prescaled_counter #(.CLK_HZ(1), .TICK_HZ(1), .WIDTH(4)) dut1 (.MCLK(clk), .RESET(rst1), .bus(b1));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic do_step(input string tag, input int cnt, input logic tc, input logic dir);
    repeat (3) begin
      @(negedge clk);
      chk({tag, " tick_idle"}, 32'(b4.TICK), 0);
      chk({tag, " tc_idle"}, 32'(b4.TC), 0);
    end
    @(negedge clk);
    chk({tag, " count"}, 32'(b4.COUNT), 32'(cnt));
    chk({tag, " tick"}, 32'(b4.TICK), 1);
    chk({tag, " tc"}, 32'(b4.TC), 32'(tc));
    chk({tag, " dir"}, 32'(b4.DIR), 32'(dir));
  endtask
  initial begin
    rst4 = 1'b1; rst1 = 1'b1;
    b4.EN = 1'b0; b4.MODE = 2'b00; b4.LOAD = 1'b0; b4.LOAD_VAL = '0;
    b1.EN = 1'b0; b1.MODE = 2'b00; b1.LOAD = 1'b0; b1.LOAD_VAL = '0;
    repeat (2) @(negedge clk);
    chk("rst count", 32'(b4.COUNT), 0);
    chk("rst tick", 32'(b4.TICK), 0);
    chk("rst tc", 32'(b4.TC), 0);
    chk("rst dir", 32'(b4.DIR), 0);
    rst4 = 1'b0; b4.EN = 1'b1;
    for (int k = 1; k <= 16; k++) do_step("up", k % 16, k == 16, 1'b1);
    b4.MODE = 2'b01;
    for (int k = 15; k >= 13; k--) do_step("down", k, k == 15, 1'b0);
    b4.MODE = 2'b10; b4.LOAD = 1'b1; b4.LOAD_VAL = 4'd13;
    @(negedge clk);
    b4.LOAD = 1'b0;
    chk("bload count", 32'(b4.COUNT), 13);
    chk("bload tick", 32'(b4.TICK), 0);
    do_step("bnc", 14, 1'b0, 1'b1);
    do_step("bnc", 15, 1'b0, 1'b1);
    do_step("bnc_top", 14, 1'b1, 1'b0);
    for (int v = 13; v >= 0; v--) do_step("bnc_dn", v, 1'b0, 1'b0);
    do_step("bnc_bot", 1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    b4.LOAD = 1'b1; b4.LOAD_VAL = 4'd9;
    @(negedge clk);
    b4.LOAD = 1'b0;
    chk("ldstep count", 32'(b4.COUNT), 9);
    chk("ldstep tick", 32'(b4.TICK), 0);
    chk("ldstep tc", 32'(b4.TC), 0);
    do_step("after_ld", 10, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    b4.EN = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("frz count", 32'(b4.COUNT), 10);
      chk("frz tick", 32'(b4.TICK), 0);
    end
    b4.EN = 1'b1;
    @(negedge clk);
    chk("resume idle", 32'(b4.TICK), 0);
    @(negedge clk);
    chk("resume count", 32'(b4.COUNT), 11);
    chk("resume tick", 32'(b4.TICK), 1);
    b4.MODE = 2'b11;
    do_step("hold", 11, 1'b0, 1'b1);
    b4.MODE = 2'b10; b4.LOAD = 1'b1; b4.LOAD_VAL = 4'd15;
    @(negedge clk);
    b4.LOAD = 1'b0;
    do_step("pre_rst", 14, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    chk("mrst count", 32'(b4.COUNT), 0);
    chk("mrst tick", 32'(b4.TICK), 0);
    chk("mrst tc", 32'(b4.TC), 0);
    chk("mrst dir", 32'(b4.DIR), 0);
    rst4 = 1'b0;
    do_step("post_rst", 1, 1'b0, 1'b1);
    chk("d1 rst count", 32'(b1.COUNT), 0);
    chk("d1 rst tick", 32'(b1.TICK), 0);
    rst1 = 1'b0; b1.EN = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      chk("d1 count", 32'(b1.COUNT), 32'(k % 16));
      chk("d1 tick", 32'(b1.TICK), 1);
      chk("d1 tc", 32'(b1.TC), 32'(k % 16 == 0));
    end
    b1.EN = 1'b0;
    @(negedge clk);
    chk("d1 off tick", 32'(b1.TICK), 0);
    chk("d1 off count", 32'(b1.COUNT), 2);
    rst1 = 1'b1;
    @(negedge clk);
    chk("d1 mrst count", 32'(b1.COUNT), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
